// File: rtl/pong_pkg.sv
// Shared types and helpers for the paddle/game-state controller.
// Optional macro PADDLE_ACCEL_EN enables per-frame paddle acceleration.
package pong_pkg;

  typedef enum logic [1:0] {
    WAIT_READY = 2'b00,
    COUNTDOWN  = 2'b01,
    PLAY       = 2'b10,
    PAUSED     = 2'b11
  } game_state_t;

  typedef logic [9:0] coord_t;

`ifdef PADDLE_ACCEL_EN
  localparam bit ACCEL_EN = 1'b1;
`else
  localparam bit ACCEL_EN = 1'b0;
`endif

  function automatic coord_t centre_y(input int screen_h, input int paddle_h);
    return coord_t'((screen_h - paddle_h) / 2);
  endfunction

endpackage

// File: rtl/paddle_axis.sv
// One paddle's vertical position and step register.
// The step grows toward STEP_CEIL while a direction stays held; a ceiling equal to BASE_STEP disables acceleration.
module paddle_axis
  import pong_pkg::*;
#(
  parameter int SCREEN_H  = 480,
  parameter int PADDLE_H  = 64,
  parameter int BASE_STEP = 4,
  parameter int STEP_CEIL = 12
) (
  input  logic   clock,
  input  logic   reset_n,
  input  logic   en_tick,
  input  logic   in_play,
  input  logic   up,
  input  logic   down,
  input  logic   recentre,
  output coord_t y
);

  localparam coord_t Y_MAX = coord_t'(SCREEN_H - PADDLE_H);
  localparam coord_t Y_CTR = centre_y(SCREEN_H, PADDLE_H);
  localparam coord_t STEP0 = coord_t'(BASE_STEP);
  localparam coord_t CEIL  = coord_t'(STEP_CEIL);

  coord_t step, step_next, move_step, y_next;
  logic   last_up, last_down, last_up_next, last_down_next;
  logic   only_up, only_down;
  logic signed [10:0] y_up, y_dn;

  assign only_up   = up && !down;
  assign only_down = down && !up;

  // A fresh direction always starts from the base step, whatever was accumulated.
  assign move_step = ((only_up && !last_up) || (only_down && !last_down)) ? STEP0 : step;
  assign y_up      = $signed({1'b0, y}) - $signed({1'b0, move_step});
  assign y_dn      = $signed({1'b0, y}) + $signed({1'b0, move_step});

  always_comb begin
    y_next         = y;
    step_next      = step;
    last_up_next   = last_up;
    last_down_next = last_down;
    if (recentre || !in_play) begin
      if (recentre) y_next = Y_CTR;
      step_next      = STEP0;
      last_up_next   = 1'b0;
      last_down_next = 1'b0;
    end else if (en_tick) begin
      last_up_next   = only_up;
      last_down_next = only_down;
      if (only_up || only_down) begin
        step_next = (move_step >= CEIL) ? CEIL : move_step + coord_t'(1);
        if (only_up)
          y_next = (y_up < 11'sd0) ? coord_t'(0) : y_up[9:0];
        else
          y_next = (y_dn > $signed({1'b0, Y_MAX})) ? Y_MAX : y_dn[9:0];
      end else begin
        step_next = STEP0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      y         <= Y_CTR;
      step      <= STEP0;
      last_up   <= 1'b0;
      last_down <= 1'b0;
    end else begin
      y         <= y_next;
      step      <= step_next;
      last_up   <= last_up_next;
      last_down <= last_down_next;
    end
  end

endmodule

// File: rtl/paddle_array_ctrl.sv
// Paddle array and ready/countdown/play/pause controller for multi-player Pong.
// Acceleration is enabled by defining PADDLE_ACCEL_EN (see pong_pkg).
module paddle_array_ctrl
  import pong_pkg::*;
#(
  parameter int NUM_PLAYERS      = 2,
  parameter int SCREEN_W         = 640,
  parameter int SCREEN_H         = 480,
  parameter int PADDLE_W         = 8,
  parameter int PADDLE_H         = 64,
  parameter int X_MARGIN         = 16,
  parameter int BASE_STEP        = 4,
  parameter int MAX_STEP         = 12,
  parameter int COUNTDOWN_FRAMES = 60
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      update_screen,
  input  logic [NUM_PLAYERS-1:0]    joystick_up,
  input  logic [NUM_PLAYERS-1:0]    joystick_down,
  input  logic [NUM_PLAYERS-1:0]    arcade_button_pressed,
  input  logic                      point_scored,
  output logic [10*NUM_PLAYERS-1:0] paddleX,
  output logic [10*NUM_PLAYERS-1:0] paddleY,
  output logic [1:0]                game_state,
  output logic [NUM_PLAYERS-1:0]    ready_mask,
  output logic [6:0]                countdown
);

  localparam int     PW        = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;
  localparam int     STEP_CEIL = ACCEL_EN ? MAX_STEP : BASE_STEP;
  localparam logic [6:0] CD_RELOAD = 7'(COUNTDOWN_FRAMES);
  localparam coord_t X_LEFT    = coord_t'(X_MARGIN);
  localparam coord_t X_RIGHT   = coord_t'(SCREEN_W - X_MARGIN - PADDLE_W);

  game_state_t            state, state_next;
  logic [NUM_PLAYERS-1:0] btn_prev, edges, ready_next;
  logic [6:0]             cd_next;
  logic [PW-1:0]          pauser, pauser_next, first_edge;
  logic                   recentre;

  assign edges      = arcade_button_pressed & ~btn_prev;
  assign game_state = state;

  // Lowest-index player with a rising edge this cycle.
  always_comb begin
    first_edge = '0;
    for (int i = NUM_PLAYERS - 1; i >= 0; i--)
      if (edges[i]) first_edge = PW'(i);
  end

  always_comb begin
    state_next  = state;
    ready_next  = ready_mask;
    cd_next     = countdown;
    pauser_next = pauser;
    recentre    = 1'b0;
    case (state)
      WAIT_READY: begin
        ready_next = ready_mask | edges;
        if (&ready_next) begin
          state_next = COUNTDOWN;
          cd_next    = CD_RELOAD;
        end
      end
      COUNTDOWN: begin
        if (update_screen) begin
          cd_next = countdown - 7'd1;
          if (countdown <= 7'd1) state_next = PLAY;
        end
      end
      PLAY: begin
        if (point_scored) begin
          state_next = COUNTDOWN;
          cd_next    = CD_RELOAD;
          recentre   = 1'b1;
        end else if (|edges) begin
          state_next  = PAUSED;
          pauser_next = first_edge;
        end
      end
      PAUSED: begin
        if (edges[pauser]) begin
          state_next = COUNTDOWN;
          cd_next    = CD_RELOAD;
        end
      end
      default: state_next = WAIT_READY;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= WAIT_READY;
      ready_mask <= '0;
      countdown  <= CD_RELOAD;
      pauser     <= '0;
      btn_prev   <= '0;
    end else begin
      state      <= state_next;
      ready_mask <= ready_next;
      countdown  <= cd_next;
      pauser     <= pauser_next;
      btn_prev   <= arcade_button_pressed;
    end
  end

  for (genvar i = 0; i < NUM_PLAYERS; i++) begin : g_paddle
    assign paddleX[10*i +: 10] = (i % 2 == 0) ? X_LEFT : X_RIGHT;

    paddle_axis #(
      .SCREEN_H (SCREEN_H),
      .PADDLE_H (PADDLE_H),
      .BASE_STEP(BASE_STEP),
      .STEP_CEIL(STEP_CEIL)
    ) u_axis (
      .clock   (clock),
      .reset_n (reset_n),
      .en_tick (state == PLAY && update_screen),
      .in_play (state == PLAY),
      .up      (joystick_up[i]),
      .down    (joystick_down[i]),
      .recentre(recentre),
      .y       (paddleY[10*i +: 10])
    );
  end

endmodule

// File: doc/paddle_array_ctrl.md
Name: paddle_array_ctrl

Overview:
Parametrised next-generation paddle and game-state controller for socially distanced Pong. It drives NUM_PLAYERS paddles, one per joystick/arcade-button set, and updates their positions once per frame on update_screen. A global ready / countdown / play / pause state machine gates movement. Paddle coordinates feed the renderer and the ball/collision logic.

Parameters:
NUM_PLAYERS, 2, number of paddles; even index = left side, odd index = right side
SCREEN_W, 640, screen width in pixels
SCREEN_H, 480, screen height in pixels
PADDLE_W, 8, paddle width in pixels
PADDLE_H, 64, paddle height in pixels
X_MARGIN, 16, gap between a paddle and its screen edge
BASE_STEP, 4, pixels moved per frame at start of a hold
MAX_STEP, 12, step ceiling with acceleration
COUNTDOWN_FRAMES, 60, frames between start/resume and play

Ports:
clock  in  1  system clock
reset_n  in  1  asynchronous active-low reset
update_screen  in  1  one-cycle frame tick
joystick_up  in  NUM_PLAYERS  per-player up level (toward y=0)
joystick_down  in  NUM_PLAYERS  per-player down level
arcade_button_pressed  in  NUM_PLAYERS  per-player button level
point_scored  in  1  one-cycle pulse from the ball logic
paddleX  out  10*NUM_PLAYERS  paddle left edge, player i at bits [10i+9:10i]
paddleY  out  10*NUM_PLAYERS  paddle top edge, same packing
game_state  out  2  00 WAIT_READY, 01 COUNTDOWN, 10 PLAY, 11 PAUSED
ready_mask  out  NUM_PLAYERS  players that have pressed ready
countdown  out  7  frames remaining in COUNTDOWN

Behaviour:
- Reset (async, reset_n=0):
  - paddleY all = (SCREEN_H-PADDLE_H)/2 (208 at defaults).
  - game_state = WAIT_READY; ready_mask = 0; countdown = COUNTDOWN_FRAMES.
  - Step registers = BASE_STEP; button edge history = 0.
  - Reset mid-play aborts any state immediately.
- paddleX is constant:
  - even i: X_MARGIN
  - odd i: SCREEN_W-X_MARGIN-PADDLE_W (616)
- Buttons:
  - Rising edge is detected per player from a 1-cycle-delayed copy.
  - An edge is consumed in its own cycle; it is not queued.
- WAIT_READY:
  - Edge from player i sets ready_mask[i].
  - When all bits are set -> COUNTDOWN, countdown = COUNTDOWN_FRAMES.
- COUNTDOWN:
  - Each update_screen decrements countdown.
  - On the tick that brings it to 0 -> PLAY.
  - Button edges are ignored.
- PLAY:
  - Any button edge -> PAUSED; record pauser = lowest-index pressing player.
  - point_scored -> COUNTDOWN, countdown reloaded, all paddles recentred.
  - point_scored has priority over a same-cycle button edge.
- PAUSED:
  - Edge from the recorded pauser -> COUNTDOWN with countdown reloaded.
  - Other players' edges are ignored.
  - point_scored is ignored.
- Motion:
  - Happens only in PLAY, on cycles with update_screen=1.
  - New paddleY is registered, so it is visible the cycle after the tick (1-cycle latency).
  - up only: y = max(y-step, 0).
  - down only: y = min(y+step, SCREEN_H-PADDLE_H) (416).
  - Both or neither: no move; step reset to BASE_STEP.
  - Arithmetic is 11-bit signed, then clamped to 10-bit; no wrap-around at either edge.
- Outside PLAY, paddles hold position and step registers reset to BASE_STEP.

Optional Feature:
Macro PADDLE_ACCEL_EN.
- Defined: each frame the same direction stays held, step = min(step+1, MAX_STEP). A direction change or release restores BASE_STEP. The move on a tick uses the pre-increment step.
- Undefined: step is fixed at BASE_STEP and MAX_STEP is unused.

Decomposition:
- Package pong_pkg:
  - game_state_t enum (WAIT_READY, COUNTDOWN, PLAY, PAUSED)
  - coord_t (logic [9:0])
  - helper function for the centre Y
- Sub-module paddle_axis: one paddle's Y register, step register, clamp and accel logic.
  - Instantiated NUM_PLAYERS times in a generate loop.
  - Inputs: en_tick, up, down, recentre.

Test Plan:
- Reset then release -> paddleY = 208/208, paddleX = 16/616, game_state = 00, ready_mask = 00.
- Press player0 then player1 button -> ready_mask 01 then 11, game_state = 01; after 60 update_screen ticks -> 10.
- PLAY, player0 up held 3 frames with accel -> y 208 -> 204 -> 199 -> 193; without macro -> 204, 200, 196.
- PLAY, player1 down held from y=410 -> 416 and stays 416; player0 up and down together -> no change, step back to 4.
- PLAY, both buttons rise in the same cycle -> PAUSED with pauser = 0; player1 press -> stays PAUSED; player0 press -> COUNTDOWN, countdown = 60.
- PLAY with paddles at 0/416, point_scored -> COUNTDOWN, paddles = 208; reset_n low mid-COUNTDOWN -> WAIT_READY immediately, without waiting for a clock.
